// File: rtl/rca_word_sequencer.sv
// Multi-cycle wide adder: one shared N-bit ripple-carry adder processes the operands a chunk per cycle, LSB first.
// Optional subtraction (op_sub port) is compiled in when RCA_SEQ_SUB_EN is defined.
module rca_word_sequencer #(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_valid,
   output logic               start_ready,
   input  logic [N*WORDS-1:0] a,
   input  logic [N*WORDS-1:0] b,
   input  logic               c_in,
`ifdef RCA_SEQ_SUB_EN
   input  logic               op_sub,
`endif
   output logic               result_valid,
   input  logic               result_ready,
   output logic [N*WORDS-1:0] sum,
   output logic               c_out,
   output logic               overflow,
   output logic               busy
);

   localparam int W    = N * WORDS;
   localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            c_out_q, c_out_d;
   logic            ovf_q, ovf_d;

   logic [W-1:0]    b_src;
   logic            cin_src;

   logic [N-1:0]    rca_x, rca_y, rca_s;
   logic [N:0]      rca_c;

   // Subtraction is A + ~B + 1, so the inversion happens once at accept time.
`ifdef RCA_SEQ_SUB_EN
   assign b_src   = op_sub ? ~b : b;
   assign cin_src = op_sub ? 1'b1 : c_in;
`else
   assign b_src   = b;
   assign cin_src = c_in;
`endif

   assign rca_x    = a_q[idx_q*N +: N];
   assign rca_y    = b_q[idx_q*N +: N];
   assign rca_c[0] = carry_q;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_fa
         assign rca_s[gi]   = rca_x[gi] ^ rca_y[gi] ^ rca_c[gi];
         assign rca_c[gi+1] = (rca_x[gi] & rca_y[gi]) | (rca_c[gi] & (rca_x[gi] ^ rca_y[gi]));
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               a_d     = a;
               b_d     = b_src;
               carry_d = cin_src;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q*N +: N] = rca_s;
            carry_d             = rca_c[N];
            if (idx_q == IDXW'(WORDS - 1)) begin
               // Signed overflow comes from the top chunk's last two carries.
               c_out_d = rca_c[N];
               ovf_d   = rca_c[N] ^ rca_c[N-1];
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (result_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign start_ready  = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign result_valid = (state_q == DONE);
   assign sum          = sum_q;
   assign c_out        = c_out_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Directed-vector bench for rca_word_sequencer (N=4, WORDS=4); subtraction vectors run when RCA_SEQ_SUB_EN is defined.
module tb_rca_word_sequencer;

   localparam int N     = 4;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   logic         clk;
   logic         rst;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         cin_i;
   logic         sub_i;
   logic         result_valid;
   logic         result_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         overflow;
   logic         busy;

   int vec_cnt;
   int err_cnt;

   rca_word_sequencer #(.N(N), .WORDS(WORDS)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .a            (a_i),
      .b            (b_i),
      .c_in         (cin_i),
`ifdef RCA_SEQ_SUB_EN
      .op_sub       (sub_i),
`endif
      .result_valid (result_valid),
      .result_ready (result_ready),
      .sum          (sum),
      .c_out        (c_out),
      .overflow     (overflow),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      @(negedge clk);
      a_i         = a;
      b_i         = b;
      cin_i       = cin;
      sub_i       = sub;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (result_valid !== 1'b1 && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handshake();
      @(negedge clk);
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input logic [W-1:0] exp_sum, input logic exp_c, input logic exp_ov);
      int lat;
      start_op(a, b, cin, sub);
      wait_result(lat);
      $display("op %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h c_out=%0d ovf=%0d lat=%0d",
               tag, a, b, cin, sub, sum, c_out, overflow, lat);
      check_val({tag, "_lat"}, lat, WORDS);
      check_val({tag, "_sum"}, sum, exp_sum);
      check_val({tag, "_cout"}, c_out, exp_c);
      check_val({tag, "_ovf"}, overflow, exp_ov);
      handshake();
      check_val({tag, "_rv_clr"}, result_valid, 1'b0);
      check_val({tag, "_busy_clr"}, busy, 1'b0);
   endtask

   initial begin
      int lat;
      int cyc;
      int rises;
      int first;
      int second;
      int rv_seen;
      logic prev;

      vec_cnt      = 0;
      err_cnt      = 0;
      rst          = 1'b1;
      start_valid  = 1'b0;
      result_ready = 1'b0;
      a_i          = '0;
      b_i          = '0;
      cin_i        = 1'b0;
      sub_i        = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_val("rst_sum", sum, 16'h0000);
      check_val("rst_rv", result_valid, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_sready", start_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      run_op("t1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_op("t2a", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("t2b", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

      // Hold off the consumer while the requester keeps poking start_valid.
      start_op(16'h1234, 16'h1111, 1'b1, 1'b0);
      check_val("t3_busy_run", busy, 1'b1);
      a_i         = 16'hFFFF;
      b_i         = 16'hFFFF;
      start_valid = 1'b1;
      wait_result(lat);
      $display("op t3: a=1234 b=1111 cin=1 -> sum=%h lat=%0d", sum, lat);
      check_val("t3_lat", lat, WORDS);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_val("t3_hold_sum", sum, 16'h2346);
         check_val("t3_hold_rv", result_valid, 1'b1);
         check_val("t3_sready", start_ready, 1'b0);
      end
      start_valid = 1'b0;
      handshake();
      check_val("t3_busy_clr", busy, 1'b0);
      check_val("t3_sready_clr", start_ready, 1'b1);
      check_val("t3_sum_kept", sum, 16'h2346);
      run_op("t3_next", 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0);

      // Asynchronous reset in the middle of RUN.
      start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check_val("t4_partial", sum[7:0], 8'h33);
      #2;
      rst = 1'b1;
      #1;
      $display("op t4: reset mid-run -> sum=%h busy=%0d", sum, busy);
      check_val("t4_sum", sum, 16'h0000);
      check_val("t4_cout", c_out, 1'b0);
      check_val("t4_ovf", overflow, 1'b0);
      check_val("t4_rv", result_valid, 1'b0);
      check_val("t4_busy", busy, 1'b0);
      check_val("t4_sready", start_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      rv_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (result_valid === 1'b1) rv_seen++;
      end
      check_val("t4_no_result", rv_seen, 0);
      run_op("t4_next", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef RCA_SEQ_SUB_EN
      run_op("t5a", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("t5b", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

      // Back-to-back issue with both handshakes held high.
      @(negedge clk);
      a_i          = 16'h0001;
      b_i          = 16'h0002;
      cin_i        = 1'b0;
      sub_i        = 1'b0;
      start_valid  = 1'b1;
      result_ready = 1'b1;
      cyc    = 0;
      rises  = 0;
      first  = 0;
      second = 0;
      prev   = 1'b0;
      while (rises < 2 && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
         if (result_valid === 1'b1 && prev == 1'b0) begin
            rises++;
            if (rises == 1) first = cyc;
            else second = cyc;
            check_val("t6_sum", sum, 16'h0003);
         end
         prev = result_valid;
      end
      start_valid = 1'b0;
      $display("op t6: back-to-back result_valid rises at cycles %0d and %0d", first, second);
      check_val("t6_rises", rises, 2);
      check_val("t6_gap", second - first, WORDS + 2);
      @(posedge clk);
      #1;
      result_ready = 1'b0;
      check_val("t6_idle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
